// File: rtl/lut_layer_pkg.sv
// Shared types, bounds and index helpers for the programmable LUT neuron layer.
// Imported by the interface, the per-neuron table and the top level.
package lut_layer_pkg;

  localparam int FANIN_MIN = 1;
  localparam int FANIN_MAX = 8;

  // Output stage occupancy: EMPTY means out_valid=0, FULL means out_valid=1.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } pipe_state_e;

  // $clog2 that never returns 0, so a single-neuron bank still gets a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int table_depth(input int fanin);
    return 1 << fanin;
  endfunction

  // LSB of neuron idx's field inside a packed vector of width-bit fields.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic bit fanin_in_range(input int fanin);
    return (fanin >= FANIN_MIN) && (fanin <= FANIN_MAX);
  endfunction

endpackage

// File: rtl/lut_layer_pipe_if.sv
// Stream and configuration signals of one LUT layer stage.
// The slave modport is the layer; the master modport is its environment.
interface lut_layer_pipe_if
  import lut_layer_pkg::*;
#(
  parameter int NEURONS  = 8,
  parameter int FANIN    = 6,
  parameter int OUT_BITS = 1,
  parameter int NIDX_W   = clog2_min1(NEURONS)
);

  logic                         in_valid;
  logic                         in_ready;
  logic [NEURONS*FANIN-1:0]     in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [NEURONS*OUT_BITS-1:0]  out_data;
  logic                         cfg_we;
  logic [NIDX_W-1:0]            cfg_neuron;
  logic [FANIN-1:0]             cfg_addr;
  logic [OUT_BITS-1:0]          cfg_data;
  logic                         cfg_err;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_err
  );

endinterface

// File: rtl/lut_neuron_reg.sv
// One neuron's truth table in flip-flops: indexed write port decoded on IDX,
// plus an asynchronous FANIN-bit read mux feeding the layer's result register.
module lut_neuron_reg
  import lut_layer_pkg::*;
#(
  parameter int FANIN    = 6,
  parameter int OUT_BITS = 1,
  parameter int NIDX_W   = 3,
  parameter int IDX      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we_i,
  input  logic [NIDX_W-1:0]   cfg_neuron_i,
  input  logic [FANIN-1:0]    cfg_addr_i,
  input  logic [OUT_BITS-1:0] cfg_data_i,
  input  logic [FANIN-1:0]    rd_addr_i,
  output logic [OUT_BITS-1:0] rd_data_o
);

  localparam int DEPTH = table_depth(FANIN);

  logic [OUT_BITS-1:0] tbl_q [DEPTH];
  logic                wr_sel;

  assign wr_sel = cfg_we_i && (cfg_neuron_i == NIDX_W'(IDX));

  // NOTE: this table is ordinary flops, not a RAM macro, so clearing every entry
  // on reset is cheap and gives a defined all-zero layer before programming.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (wr_sel) begin
      tbl_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  assign rd_data_o = tbl_q[rd_addr_i];

endmodule

// File: rtl/lut_layer_pipe.sv
// Runtime-programmable bank of LUT neurons with a one-entry valid/ready output
// register; table writes block lookups for the cycle in which they occur.
module lut_layer_pipe
  import lut_layer_pkg::*;
#(
  parameter int NEURONS  = 8,
  parameter int FANIN    = 6,
  parameter int OUT_BITS = 1,
  parameter int NIDX_W   = clog2_min1(NEURONS)
) (
  input  logic            clk,
  input  logic            rst,
  lut_layer_pipe_if.slave bus
);

  localparam int RES_W = NEURONS * OUT_BITS;

  pipe_state_e      state_q;
  logic [RES_W-1:0] out_data_q;
  logic [RES_W-1:0] result_d;
  logic             cfg_err_q;
  logic             cfg_bad;
  logic             xfer;

  // A write cycle never accepts a lookup, so no lookup can see a half-updated table.
  assign bus.in_ready = ((state_q == ST_EMPTY) || bus.out_ready) && !bus.cfg_we;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign cfg_bad      = bus.cfg_we && (int'(bus.cfg_neuron) >= NEURONS);

  for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
    lut_neuron_reg #(
      .FANIN    (FANIN),
      .OUT_BITS (OUT_BITS),
      .NIDX_W   (NIDX_W),
      .IDX      (n)
    ) u_neuron (
      .clk          (clk),
      .rst          (rst),
      .cfg_we_i     (bus.cfg_we),
      .cfg_neuron_i (bus.cfg_neuron),
      .cfg_addr_i   (bus.cfg_addr),
      .cfg_data_i   (bus.cfg_data),
      .rd_addr_i    (bus.in_data[slice_lsb(n, FANIN) +: FANIN]),
      .rd_data_o    (result_d[slice_lsb(n, OUT_BITS) +: OUT_BITS])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= cfg_bad;
      unique case (state_q)
        ST_EMPTY: begin
          if (xfer) begin
            state_q    <= ST_FULL;
            out_data_q <= result_d;
          end
        end
        ST_FULL: begin
          // Drain leaves out_data_q untouched; only out_valid drops.
          if (xfer) begin
            out_data_q <= result_d;
          end else if (bus.out_ready) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Self-checking bench for lut_layer_pipe (4 neurons, FANIN=6, OUT_BITS=1):
// directed vector table, hand-written handshake sequences, and a random phase
// scored against a plain array model of the truth tables.
module tb_lut_layer_pipe;

  localparam int N  = 4;
  localparam int FI = 6;
  localparam int OB = 1;
  localparam int NW = 3;

  typedef struct {
    logic [N*FI-1:0] in_data;
    logic [N*OB-1:0] exp;
  } vec_t;

  logic clk;
  logic rst;

  lut_layer_pipe_if #(.NEURONS(N), .FANIN(FI), .OUT_BITS(OB), .NIDX_W(NW)) bus ();

  lut_layer_pipe #(.NEURONS(N), .FANIN(FI), .OUT_BITS(OB), .NIDX_W(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  bit model_tbl [N][64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] model_lookup(input logic [N*FI-1:0] d);
    logic [N-1:0] r;
    for (int n = 0; n < N; n++) begin
      int a;
      a = int'((d >> (FI * n)) & 24'h3f);
      r[n] = model_tbl[n][a];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < N; n++)
      for (int a = 0; a < 64; a++)
        model_tbl[n][a] = 1'b0;
  endtask

  task automatic drive_idle();
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_neuron = '0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
  endtask

  task automatic cfg_write(input int n, input int a, input bit d);
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = NW'(n);
    bus.cfg_addr   = FI'(a);
    bus.cfg_data   = OB'(d);
    step();
    bus.cfg_we = 1'b0;
    if (n < N) model_tbl[n][a] = d;
  endtask

  task automatic lookup(input string name, input logic [N*FI-1:0] d, input logic [N-1:0] exp);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_data"}, 32'(bus.out_data), 32'(exp));
  endtask

  vec_t vecs[6];
  logic [N-1:0] q[$];
  logic [N-1:0] stream_exp[16];
  bit prev_bad;
  bit exp_ready;
  bit consume;

  initial begin
    checks   = 0;
    failures = 0;
    model_clear();

    vecs[0] = '{{6'd0, 6'd0, 6'd0, 6'd17}, 4'b0001};
    vecs[1] = '{{6'd0, 6'd0, 6'd0, 6'd16}, 4'b0000};
    vecs[2] = '{{6'd0, 6'd0, 6'd0, 6'd63}, 4'b0001};
    vecs[3] = '{{6'd0, 6'd0, 6'd17, 6'd0}, 4'b0000};
    vecs[4] = '{{6'd63, 6'd63, 6'd63, 6'd49}, 4'b0001};
    vecs[5] = '{{6'd0, 6'd0, 6'd0, 6'd1}, 4'b0000};

    // Reset state
    rst = 1'b1;
    drive_idle();
    bus.in_data = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    lookup("first", '0, 4'b0000);

    // Neuron 0: entry is 1 wherever address bits 4 and 0 are both set
    drive_idle();
    for (int a = 0; a < 64; a++)
      if ((a & 17) == 17) cfg_write(0, a, 1'b1);

    foreach (vecs[i]) lookup($sformatf("vec%0d", i), vecs[i].in_data, vecs[i].exp);

    // Backpressure hold, then release accepts in the same cycle
    lookup("hold_pre", {6'd0, 6'd0, 6'd0, 6'd17}, 4'b0001);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = {6'd0, 6'd0, 6'd0, 6'd16};
    #1;
    check("hold_in_ready0", 32'(bus.in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("hold%0d_valid", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("hold%0d_data", c), 32'(bus.out_data), 32'd1);
      check($sformatf("hold%0d_ready", c), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("release_valid", 32'(bus.out_valid), 32'd1);
    check("release_data", 32'(bus.out_data), 32'd0);

    // Drain keeps last data
    lookup("drain_pre", {6'd0, 6'd0, 6'd0, 6'd63}, 4'b0001);
    step();
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_data_kept", 32'(bus.out_data), 32'd1);

    // Write and lookup in the same cycle: write wins, lookup next cycle sees it
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = 3'd2;
    bus.cfg_addr   = 6'd5;
    bus.cfg_data   = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = {6'd0, 6'd5, 6'd0, 6'd0};
    #1;
    check("wr_blocks_ready", 32'(bus.in_ready), 32'd0);
    step();
    model_tbl[2][5] = 1'b1;
    bus.cfg_we = 1'b0;
    check("wr_no_xfer", 32'(bus.out_valid), 32'd0);
    #1;
    check("wr_after_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("wr_visible_data", 32'(bus.out_data), 32'b0100);
    check("wr_visible_model", 32'(bus.out_data), 32'(model_lookup({6'd0, 6'd5, 6'd0, 6'd0})));

    // Out-of-range neuron: one-cycle error, tables untouched
    step();
    cfg_write(5, 0, 1'b1);
    check("err_pulse", 32'(bus.cfg_err), 32'd1);
    step();
    check("err_clear", 32'(bus.cfg_err), 32'd0);
    lookup("err_tbl0", '0, 4'b0000);
    lookup("err_tbl1", {6'd0, 6'd5, 6'd0, 6'd17}, 4'b0101);

    // Randomised handshake/config phase scored against the array model
    drive_idle();
    step();
    q.delete();
    prev_bad = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      check("rand_err", 32'(bus.cfg_err), 32'(prev_bad));
      check("rand_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_data    = 24'($urandom);
      bus.cfg_we     = ($urandom_range(0, 7) == 0);
      bus.cfg_neuron = 3'($urandom_range(0, 5));
      bus.cfg_addr   = 6'($urandom);
      bus.cfg_data   = 1'($urandom);
      #1;
      exp_ready = ((q.size() == 0) || bus.out_ready) && !bus.cfg_we;
      check("rand_ready", 32'(bus.in_ready), 32'(exp_ready));
      consume = (q.size() != 0) && bus.out_ready;
      if (consume) check("rand_data", 32'(bus.out_data), 32'(q.pop_front()));
      if (bus.in_valid && exp_ready) q.push_back(model_lookup(bus.in_data));
      prev_bad = bus.cfg_we && (int'(bus.cfg_neuron) >= N);
      if (bus.cfg_we && int'(bus.cfg_neuron) < N)
        model_tbl[int'(bus.cfg_neuron)][int'(bus.cfg_addr)] = bus.cfg_data[0];
      step();
    end
    drive_idle();
    step();
    step();
    check("rand_drained", 32'(bus.out_valid), 32'd0);

    // Back-to-back stream, then reset mid-stream
    cfg_write(0, 17, 1'b1);
    cfg_write(2, 5, 1'b1);
    for (int k = 0; k < 16; k++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = 24'($urandom);
      bus.out_ready = 1'b1;
      stream_exp[k] = model_lookup(bus.in_data);
      step();
      check($sformatf("stream%0d_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("stream%0d_data", k), 32'(bus.out_data), 32'(stream_exp[k]));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_data", 32'(bus.out_data), 32'd0);
    lookup("midrst_cleared", {6'd0, 6'd5, 6'd0, 6'd17}, 4'b0000);

    // Reset and write together: the write is lost
    rst            = 1'b1;
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = 3'd1;
    bus.cfg_addr   = 6'd3;
    bus.cfg_data   = 1'b1;
    step();
    rst        = 1'b0;
    bus.cfg_we = 1'b0;
    check("rstwr_err", 32'(bus.cfg_err), 32'd0);
    lookup("rstwr_lost", {6'd0, 6'd0, 6'd3, 6'd0}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
